// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register-file dump reader.
package reg_dump_pkg;

   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned AW_DEF    = 5;
   localparam int unsigned DW_DEF    = 32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HOLD = 3'd1,
      ST_READ = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Command, register-file read port and beat stream of the dump reader.
interface reg_dump_reader_if #(
   parameter int unsigned AW = reg_dump_pkg::AW_DEF,
   parameter int unsigned DW = reg_dump_pkg::DW_DEF
);

   logic          start;
   logic [AW-1:0] first_addr;
   logic [AW-1:0] last_addr;
   logic          abort;
   logic          hold_core;
   logic [AW-1:0] rs_addr;
   logic [DW-1:0] rs_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;

   // master: the dump reader itself
   modport master (
      input  start, first_addr, last_addr, abort, rs_data, out_ready,
      output hold_core, rs_addr, out_valid, out_addr, out_data, out_last, busy, done
   );

   // slave: core, register file and beat sink around the reader
   modport slave (
      output start, first_addr, last_addr, abort, rs_data, out_ready,
      input  hold_core, rs_addr, out_valid, out_addr, out_data, out_last, busy, done
   );

endinterface

// File: rtl/reg_dump_reader.sv
// Freezes the core, walks a register range through one read port and streams
// (addr, data, last) beats over valid/ready.
module reg_dump_reader
   import reg_dump_pkg::*;
#(
   parameter int unsigned NREGS = reg_dump_pkg::NREGS_DEF,
   parameter int unsigned AW    = reg_dump_pkg::AW_DEF,
   parameter int unsigned DW    = reg_dump_pkg::DW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   reg_dump_reader_if.master dump
);

   state_e        state_q, state_d;
   logic [AW-1:0] cur_q, cur_d;
   logic [AW-1:0] end_q, end_d;
   logic [AW-1:0] out_addr_q, out_addr_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_last_q, out_last_d;
   logic          dumping;
   logic          beat_accept;

   assign dumping     = (state_q == ST_HOLD) || (state_q == ST_READ) || (state_q == ST_SEND);
   assign beat_accept = (state_q == ST_SEND) && dump.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cur_q      <= '0;
         end_q      <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         end_q      <= end_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      end_d      = end_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;

      unique case (state_q)
         ST_IDLE: begin
            if (dump.start && !dump.abort) begin
               state_d = ST_HOLD;
               cur_d   = dump.first_addr;
               end_d   = dump.last_addr;
            end
         end
         ST_HOLD: state_d = ST_READ;
         ST_READ: begin
            state_d    = ST_SEND;
            out_addr_d = cur_q;
            out_data_d = dump.rs_data;
            out_last_d = (cur_q == end_q);
         end
         ST_SEND: begin
            if (beat_accept) begin
               if (out_last_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_READ;
                  cur_d   = (cur_q == AW'(NREGS - 1)) ? '0 : cur_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (dump.abort && dumping) begin
         state_d = ST_IDLE;
      end

      // Beat registers are cleared on every return to IDLE so an aborted or
      // finished dump leaves the stream outputs at zero.
      if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
         out_addr_d = '0;
         out_data_d = '0;
         out_last_d = 1'b0;
      end
   end

   assign dump.hold_core = dumping;
   assign dump.busy      = (state_q != ST_IDLE);
   assign dump.done      = (state_q == ST_DONE);
   assign dump.out_valid = (state_q == ST_SEND);
   assign dump.rs_addr   = (state_q == ST_READ) ? cur_q : '0;
   assign dump.out_addr  = out_addr_q;
   assign dump.out_data  = out_data_q;
   assign dump.out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: modelled register file, scoreboard of
// expected beats, backpressure, abort and reset scenarios.
module tb_reg_dump_reader;

   localparam int unsigned NONE = 999;

   logic clk = 1'b0;
   logic reset;

   reg_dump_reader_if #(.AW(5), .DW(32)) bus ();

   reg_dump_reader #(.NREGS(32), .AW(5), .DW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .dump  (bus)
   );

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic [31:0] rf     [32];
   logic [31:0] exp_rf [32];
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   beat_t       sb [$];

   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;
   int unsigned fail_cnt  = 0;

   always #5 clk = ~clk;

   // Core write port: writes are blocked while the reader holds the core.
   always @(posedge clk) begin
      if (we && !bus.hold_core) rf[wa] <= wd;
   end

   assign bus.rs_data = rf[bus.rs_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {17'd0, bus.hold_core, bus.busy, bus.done, bus.out_valid, bus.out_last,
              bus.rs_addr, bus.out_addr, bus.out_data};
   endfunction

   task automatic start_dump(input logic [4:0] f, input logic [4:0] l,
                             input bit wr, input logic [31:0] wdata);
      logic [4:0] span;
      logic [4:0] a;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.first_addr = f;
      bus.last_addr  = l;
      if (wr) begin
         we = 1'b1;
         wa = f;
         wd = wdata;
         exp_rf[f] = wdata;
      end
      @(negedge clk);
      bus.start = 1'b0;
      we        = 1'b0;
      span = l - f;
      for (int unsigned i = 0; i <= 32'(span); i++) begin
         a = f + 5'(i);
         sb.push_back('{addr: a, data: exp_rf[a], last: (a == l)});
      end
   endtask

   task automatic drain(input int unsigned budget, input int unsigned stall_beat,
                        input int unsigned stall_len, input int unsigned abort_beat,
                        output int unsigned beats, output int unsigned done_cnt,
                        output int unsigned done_cyc, output int unsigned first_vld,
                        output int unsigned last_hs);
      int unsigned stall_left;
      int unsigned tail;
      bit          held;
      bit          aborted;
      logic [38:0] hv;
      beat_t       e;
      stall_left = stall_len;
      tail = 0; held = 1'b0; aborted = 1'b0; hv = '0;
      beats = 0; done_cnt = 0; done_cyc = 0; first_vld = 0; last_hs = 0;
      for (int unsigned c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (bus.done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (bus.out_valid && first_vld == 0) first_vld = c;
         if (held) check("stall_stable", {bus.out_valid, bus.out_addr, bus.out_data, bus.out_last}, hv);
         held = 1'b0;
         if (aborted) break;
         if (done_cnt > 0) begin
            tail++;
            if (tail > 2) break;
         end
         bus.out_ready = 1'b1;
         if (bus.out_valid && beats == stall_beat && stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
            held = 1'b1;
            hv = {bus.out_valid, bus.out_addr, bus.out_data, bus.out_last};
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("extra_beat", {bus.out_addr, bus.out_data, bus.out_last}, '0);
            end else begin
               e = sb.pop_front();
               check("beat", {bus.out_addr, bus.out_data, bus.out_last}, {e.addr, e.data, e.last});
            end
            beats++;
            last_hs = c;
            if (beats - 1 == abort_beat) begin
               bus.abort = 1'b1;
               aborted   = 1'b1;
            end
         end
      end
   endtask

   initial begin
      int unsigned beats, dcnt, dcyc, fv, lhs;
      reset = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.first_addr = '0; bus.last_addr = '0;
      bus.out_ready = 1'b0;
      we = 1'b0; wa = '0; wd = '0;
      repeat (2) @(negedge clk);
      check("reset_outs", outs(), '0);
      reset = 1'b0;

      for (int unsigned i = 0; i < 32; i++) begin
         @(negedge clk);
         we = 1'b1; wa = 5'(i); wd = 32'hA000_0000 + i;
         exp_rf[i] = 32'hA000_0000 + i;
      end
      @(negedge clk);
      we = 1'b0;

      // start together with abort in IDLE stays idle
      bus.start = 1'b1; bus.abort = 1'b1; bus.first_addr = 5'd0; bus.last_addr = 5'd3;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      check("start_abort_idle", outs(), '0);

      // full range
      start_dump(5'd0, 5'd31, 1'b0, '0);
      check("hold_after_start", {bus.hold_core, bus.busy, bus.out_valid}, 3'b110);
      drain(200, NONE, 0, NONE, beats, dcnt, dcyc, fv, lhs);
      check("full_beats", beats, 32);
      check("full_done_cnt", dcnt, 1);
      check("full_first_valid", fv, 2);
      check("full_done_cyc", dcyc, 65);
      check("full_done_after_accept", dcyc, lhs + 1);
      check("full_sb_empty", sb.size(), 0);

      // wrapping range
      start_dump(5'd30, 5'd1, 1'b0, '0);
      drain(60, NONE, 0, NONE, beats, dcnt, dcyc, fv, lhs);
      check("wrap_beats", beats, 4);
      check("wrap_done_cnt", dcnt, 1);
      check("wrap_done_cyc", dcyc, 9);
      check("wrap_sb_empty", sb.size(), 0);

      // single register
      start_dump(5'd7, 5'd7, 1'b0, '0);
      drain(30, NONE, 0, NONE, beats, dcnt, dcyc, fv, lhs);
      check("single_beats", beats, 1);
      check("single_done_cyc", dcyc, 3);
      check("single_done_after_accept", dcyc, lhs + 1);

      // backpressure for 5 cycles on the third beat
      start_dump(5'd4, 5'd9, 1'b0, '0);
      drain(80, 2, 5, NONE, beats, dcnt, dcyc, fv, lhs);
      check("bp_beats", beats, 6);
      check("bp_done_cnt", dcnt, 1);
      check("bp_done_cyc", dcyc, 18);
      check("bp_sb_empty", sb.size(), 0);

      // write on the start edge lands before the read
      start_dump(5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF);
      check("wr_hold_next", bus.hold_core, 1'b1);
      drain(30, NONE, 0, NONE, beats, dcnt, dcyc, fv, lhs);
      check("wr_beats", beats, 1);
      check("wr_done_cnt", dcnt, 1);

      // abort in SEND on the fourth beat
      start_dump(5'd0, 5'd31, 1'b0, '0);
      drain(100, NONE, 0, 3, beats, dcnt, dcyc, fv, lhs);
      bus.abort = 1'b0;
      check("abort_beats", beats, 4);
      check("abort_no_done", dcnt, 0);
      check("abort_outs", outs(), '0);
      sb.delete();
      drain(6, NONE, 0, NONE, beats, dcnt, dcyc, fv, lhs);
      check("abort_quiet_beats", beats, 0);
      check("abort_quiet_done", dcnt, 0);

      // asynchronous reset mid-dump
      start_dump(5'd0, 5'd31, 1'b0, '0);
      drain(7, NONE, 0, NONE, beats, dcnt, dcyc, fv, lhs);
      check("rst_pre_beats", beats, 3);
      #2 reset = 1'b1;
      #1 check("rst_async_outs", outs(), '0);
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      drain(6, NONE, 0, NONE, beats, dcnt, dcyc, fv, lhs);
      check("rst_quiet_beats", beats, 0);
      check("rst_quiet_done", dcnt, 0);

      // start while busy is ignored and the range is unchanged
      start_dump(5'd10, 5'd12, 1'b0, '0);
      bus.start = 1'b1; bus.first_addr = 5'd0; bus.last_addr = 5'd31;
      @(negedge clk);
      bus.start = 1'b0;
      drain(40, NONE, 0, NONE, beats, dcnt, dcyc, fv, lhs);
      check("busy_start_beats", beats, 3);
      check("busy_start_done", dcnt, 1);
      check("busy_start_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
